tdd_frame_timer: RTL and testbench

- Downstream consumer of the AXI-to-stream register block's timing outputs.
- Generates the TDD/FDD frame counter, frame-start strobe and TX/RX window enables that gate the AXI2S input and output streams.
- Applies the one-shot FRAME_ADJ correction and returns `adj_pending` for the status register.

---
 rtl/tdd_frame_timer.sv | 118 +++++++++++
 tb/tb_tdd_frame_timer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdd_frame_timer.sv
// TDD/FDD frame timer: frame counter, frame-start strobe, TX/RX window enables
// and one-shot frame-length adjustment.
module tdd_frame_timer #(
    parameter int unsigned CW     = 24,
    parameter int unsigned NW     = 32,
    parameter int unsigned MINLEN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          tddmode,
    input  logic [CW-1:0] frame_len,
    input  logic [CW-1:0] frame_adj,
    input  logic          adj_wr,
    input  logic [CW-1:0] tstart,
    input  logic [CW-1:0] tend,
    input  logic [CW-1:0] rstart,
    input  logic [CW-1:0] rend,
    output logic [CW-1:0] frame_cnt,
    output logic [NW-1:0] frame_num,
    output logic          frame_start,
    output logic          tx_win,
    output logic          rx_win,
    output logic          adj_pending
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cur_len, len_nx, adj_reg, adj_reg_nx, cnt_nx, eff_len;
    logic [NW-1:0] num_nx;
    logic          start_nx, pend_nx, tx_nx, rx_nx;
    logic signed [CW+1:0] len_sum;

    function automatic logic in_win(input logic [CW-1:0] c, s, e);
        if (s <= e) return (c >= s) && (c <= e);
        else        return (c >= s) || (c <= e);
    endfunction

    // Effective length for a frame starting now, clamped to [MINLEN, 2^CW-1]
    always_comb begin
        len_sum = $signed({2'b00, frame_len});
        if (adj_pending)
            len_sum = len_sum + $signed({{2{adj_reg[CW-1]}}, adj_reg});
        if (len_sum < $signed((CW+2)'(MINLEN)))
            eff_len = CW'(MINLEN);
        else if (len_sum > $signed({2'b00, {CW{1'b1}}}))
            eff_len = '1;
        else
            eff_len = len_sum[CW-1:0];
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = '0;
        num_nx     = '0;
        start_nx   = 1'b0;
        len_nx     = cur_len;
        pend_nx    = adj_pending;
        adj_reg_nx = adj_reg;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nx = RUN;
                    start_nx = 1'b1;
                    len_nx   = eff_len;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nx = IDLE;
                end else if (frame_cnt == cur_len - 1'b1) begin
                    num_nx   = frame_num + 1'b1;
                    start_nx = 1'b1;
                    len_nx   = eff_len;
                end else begin
                    cnt_nx = frame_cnt + 1'b1;
                    num_nx = frame_num;
                end
            end
            default: state_nx = IDLE;
        endcase
        // A write on a frame-start edge wins over the clear, deferring it one frame
        if (start_nx && adj_pending)
            pend_nx = 1'b0;
        if (adj_wr) begin
            adj_reg_nx = frame_adj;
            pend_nx    = 1'b1;
        end
        tx_nx = (state_nx == RUN) && (!tddmode || in_win(cnt_nx, tstart, tend));
        rx_nx = (state_nx == RUN) && (!tddmode || in_win(cnt_nx, rstart, rend));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            frame_cnt   <= '0;
            frame_num   <= '0;
            frame_start <= 1'b0;
            tx_win      <= 1'b0;
            rx_win      <= 1'b0;
            adj_pending <= 1'b0;
            cur_len     <= CW'(MINLEN);
            adj_reg     <= '0;
        end else begin
            state       <= state_nx;
            frame_cnt   <= cnt_nx;
            frame_num   <= num_nx;
            frame_start <= start_nx;
            tx_win      <= tx_nx;
            rx_win      <= rx_nx;
            adj_pending <= pend_nx;
            cur_len     <= len_nx;
            adj_reg     <= adj_reg_nx;
        end
    end

endmodule

// File: tb/tb_tdd_frame_timer.sv
// Directed self-checking bench for tdd_frame_timer.
module tb_tdd_frame_timer;

    localparam int CW = 24;
    localparam int NW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          tddmode = 1'b0;
    logic          adj_wr = 1'b0;
    logic [CW-1:0] frame_len = '0;
    logic [CW-1:0] frame_adj = '0;
    logic [CW-1:0] tstart = '0;
    logic [CW-1:0] tend = '0;
    logic [CW-1:0] rstart = '0;
    logic [CW-1:0] rend = '0;
    logic [CW-1:0] frame_cnt;
    logic [NW-1:0] frame_num;
    logic          frame_start, tx_win, rx_win, adj_pending;

    int n_cmp = 0;
    int n_bad = 0;

    tdd_frame_timer #(.CW(CW), .NW(NW), .MINLEN(2)) dut (
        .clk(clk), .rst(rst), .en(en), .tddmode(tddmode),
        .frame_len(frame_len), .frame_adj(frame_adj), .adj_wr(adj_wr),
        .tstart(tstart), .tend(tend), .rstart(rstart), .rend(rend),
        .frame_cnt(frame_cnt), .frame_num(frame_num), .frame_start(frame_start),
        .tx_win(tx_win), .rx_win(rx_win), .adj_pending(adj_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to_cnt(input int target);
        int i = 0;
        while (frame_cnt !== CW'(target) && i < 100) begin
            tick();
            i++;
        end
        if (frame_cnt !== CW'(target)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_to_cnt: frame_cnt=%0d required %0d within 100 cycles", frame_cnt, target);
        end
    endtask

    // Called with frame_start high; returns cycles until the next frame_start
    task automatic measure_frame(output int len);
        len = 0;
        do begin
            tick();
            len++;
        end while (frame_start !== 1'b1 && len < 100);
    endtask

    task automatic last_cnt_of_frame(output int last);
        int i = 0;
        last = int'(frame_cnt);
        tick();
        while (frame_start !== 1'b1 && i < 100) begin
            last = int'(frame_cnt);
            tick();
            i++;
        end
    endtask

    task automatic restart();
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if ({frame_cnt, frame_num, frame_start, tx_win, rx_win, adj_pending} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: cnt=%0d num=%0d start=%b tx=%b rx=%b pend=%b required all 0",
                     frame_cnt, frame_num, frame_start, tx_win, rx_win, adj_pending);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({frame_cnt, frame_num, frame_start, tx_win, rx_win} !== '0) begin
            n_bad++;
            $display("FAIL idle_state: cnt=%0d num=%0d start=%b tx=%b rx=%b required all 0",
                     frame_cnt, frame_num, frame_start, tx_win, rx_win);
        end
    endtask

    task automatic test_basic();
        int c;
        logic es, et, er;
        frame_len = 10; tddmode = 1'b1;
        tstart = 2; tend = 4; rstart = 6; rend = 8;
        en = 1'b1;
        tick();
        for (int k = 0; k <= 30; k++) begin
            c  = k % 10;
            es = (c == 0);
            et = (c >= 2 && c <= 4);
            er = (c >= 6 && c <= 8);
            n_cmp++;
            if (frame_cnt !== CW'(c) || frame_start !== es || tx_win !== et ||
                rx_win !== er || frame_num !== NW'(k / 10)) begin
                n_bad++;
                $display("FAIL basic k=%0d: cnt=%0d start=%b tx=%b rx=%b num=%0d required %0d %b %b %b %0d",
                         k, frame_cnt, frame_start, tx_win, rx_win, frame_num, c, es, et, er, k / 10);
            end
            if (k < 30) tick();
        end
    endtask

    task automatic test_wrap();
        int c;
        logic et, er;
        en = 1'b0;
        tick();
        tstart = 8; tend = 1;
        en = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            c  = k % 10;
            et = (c >= 8 || c <= 1);
            er = (c >= 6 && c <= 8);
            n_cmp++;
            if (frame_cnt !== CW'(c) || tx_win !== et || rx_win !== er) begin
                n_bad++;
                $display("FAIL wrap_win k=%0d: cnt=%0d tx=%b rx=%b required %0d %b %b",
                         k, frame_cnt, tx_win, rx_win, c, et, er);
            end
            tick();
        end
        tddmode = 1'b0;
        tick();
        for (int k = 0; k < 12; k++) begin
            n_cmp++;
            if (tx_win !== 1'b1 || rx_win !== 1'b1) begin
                n_bad++;
                $display("FAIL fdd_win k=%0d: tx=%b rx=%b required 1 1", k, tx_win, rx_win);
            end
            tick();
        end
        tddmode = 1'b1; tstart = 2; tend = 4;
    endtask

    task automatic test_adjust();
        int len;
        restart();
        run_to_cnt(5);
        frame_adj = 3; adj_wr = 1'b1;
        tick();
        adj_wr = 1'b0;
        n_cmp++;
        if (adj_pending !== 1'b1 || frame_cnt !== CW'(6)) begin
            n_bad++;
            $display("FAIL adj_set: pend=%b cnt=%0d required 1 6", adj_pending, frame_cnt);
        end
        run_to_cnt(0);
        n_cmp++;
        if (adj_pending !== 1'b0 || frame_start !== 1'b1) begin
            n_bad++;
            $display("FAIL adj_clear: pend=%b start=%b required 0 1", adj_pending, frame_start);
        end
        measure_frame(len);
        n_cmp++;
        if (len != 13) begin
            n_bad++;
            $display("FAIL adj_frame_len: got %0d required 13", len);
        end
        measure_frame(len);
        n_cmp++;
        if (len != 10) begin
            n_bad++;
            $display("FAIL post_adj_len: got %0d required 10", len);
        end
    endtask

    task automatic test_same_edge();
        int len;
        int exp_len[4] = '{2, 2, 2, 10};
        run_to_cnt(9);
        frame_adj = 3; adj_wr = 1'b1;
        tick();
        adj_wr = 1'b0;
        n_cmp++;
        if (frame_start !== 1'b1 || adj_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL same_edge_pend: start=%b pend=%b required 1 1", frame_start, adj_pending);
        end
        measure_frame(len);
        n_cmp++;
        if (len != 10 || adj_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL same_edge_defer: len=%0d pend=%b required 10 0", len, adj_pending);
        end
        measure_frame(len);
        n_cmp++;
        if (len != 13) begin
            n_bad++;
            $display("FAIL same_edge_apply: len=%0d required 13", len);
        end
        run_to_cnt(5);
        frame_adj = 24'hFFFFEC; adj_wr = 1'b1;
        tick();
        adj_wr = 1'b0;
        run_to_cnt(0);
        frame_len = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) frame_len = 10;
            measure_frame(len);
            n_cmp++;
            if (len != exp_len[i]) begin
                n_bad++;
                $display("FAIL clamp_len[%0d]: got %0d required %0d", i, len, exp_len[i]);
            end
        end
    endtask

    task automatic test_len_change();
        int last;
        restart();
        run_to_cnt(3);
        frame_len = 6;
        last_cnt_of_frame(last);
        n_cmp++;
        if (last != 9) begin
            n_bad++;
            $display("FAIL len_change_cur: last cnt %0d required 9", last);
        end
        last_cnt_of_frame(last);
        n_cmp++;
        if (last != 5) begin
            n_bad++;
            $display("FAIL len_change_next: last cnt %0d required 5", last);
        end
    endtask

    task automatic test_disable();
        run_to_cnt(4);
        en = 1'b0;
        tick();
        n_cmp++;
        if ({frame_cnt, frame_num, frame_start, tx_win, rx_win} !== '0) begin
            n_bad++;
            $display("FAIL disable: cnt=%0d num=%0d start=%b tx=%b rx=%b required all 0",
                     frame_cnt, frame_num, frame_start, tx_win, rx_win);
        end
        en = 1'b1;
        tick();
        n_cmp++;
        if (frame_start !== 1'b1 || frame_cnt !== '0 || frame_num !== '0) begin
            n_bad++;
            $display("FAIL reenable: start=%b cnt=%0d num=%0d required 1 0 0",
                     frame_start, frame_cnt, frame_num);
        end
        frame_len = 10;
    endtask

    task automatic test_reset_mid();
        int len;
        restart();
        run_to_cnt(5);
        frame_adj = 3; adj_wr = 1'b1;
        tick();
        adj_wr = 1'b0;
        run_to_cnt(7);
        n_cmp++;
        if (adj_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_pend: pend=%b required 1", adj_pending);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({frame_cnt, frame_num, frame_start, tx_win, rx_win, adj_pending} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: cnt=%0d num=%0d start=%b tx=%b rx=%b pend=%b required all 0",
                     frame_cnt, frame_num, frame_start, tx_win, rx_win, adj_pending);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_cmp++;
        if (frame_start !== 1'b1 || frame_cnt !== '0 || adj_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_start: start=%b cnt=%0d pend=%b required 1 0 0",
                     frame_start, frame_cnt, adj_pending);
        end
        measure_frame(len);
        n_cmp++;
        if (len != 10) begin
            n_bad++;
            $display("FAIL post_reset_len: got %0d required 10", len);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_adjust();
        test_same_edge();
        test_len_change();
        test_disable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
